poly_add_half_seq: RTL and testbench
====================================

Name: poly_add_half_seq

Overview:
- Sequencer that streams two 256-coefficient Kyber polynomials from dual-read coefficient memory.
- Applies modular add (q=3329) per coefficient, optionally followed by divide-by-2 mod q.
- Writes results back through a single write port.
- Used for poly add and for the INTT butterfly's add-and-halve pass; owns address generation, read-latency alignment, the result register and start/done handshaking.

Parameters:
- N, 256, coefficients per pass (power of 2, >=2)
- ADDR_W, 8, address width, log2(N)
- RD_LAT, 1, memory read latency in cycles (1..3); rd_a/rd_b valid RD_LAT cycles after rd_en/rd_addr

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  single-cycle pass request
- mode  in  2  1 = add then div2; any other value = add only
- busy  out  1  pass in progress
- done  out  1  single-cycle pass-complete pulse
- rd_en  out  1  read strobe
- rd_addr  out  ADDR_W  read address for both operand memories
- rd_a  in  12  operand A read data
- rd_b  in  12  operand B read data
- wr_en  out  1  write strobe
- wr_addr  out  ADDR_W  write address
- wr_data  out  12  reduced result

Behaviour:
- Reset values (rst_n low at a clk edge): state=IDLE; busy, done, rd_en, wr_en = 0; rd_addr, wr_addr, wr_data = 0; pipeline valid bits cleared.
- Reset mid-pass: pass abandoned, no further writes, no done pulse.
- States: IDLE -> RUN -> DRAIN -> FIN -> IDLE.
- IDLE:
  - start=1 at edge E0 latches mode into mode_q, enters RUN.
  - start while busy or during FIN is ignored; mode changes mid-pass are ignored.
- RUN:
  - rd_en=1 and rd_addr=k during cycle k+1 after E0, k=0..N-1, one address per cycle, no gaps.
  - After addr N-1 is issued, go to DRAIN.
- DRAIN:
  - rd_en=0. Wait until the last write has been issued (RD_LAT+1 cycles), then go to FIN.
- FIN:
  - done=1 for exactly one cycle, then IDLE.
  - busy=1 from the cycle after E0 through the FIN cycle inclusive.
- Pipeline:
  - A valid/address delay line of depth RD_LAT tracks each read.
  - When data returns, the result is computed combinationally and registered.
  - wr_en=1, wr_addr=k, wr_data=f(a,b) RD_LAT+1 cycles after the rd_en cycle for k.
  - Writes are contiguous, ascending 0..N-1.
- Timing for N=256, RD_LAT=1:
  - rd cycles 1..256
  - wr cycles 3..258
  - done cycle 259
  - busy cycles 1..259
- Arithmetic (inputs canonical 0..3328):
  - s = a+b, 13-bit.
  - r = s-3329 if s>=3329, else s.
  - mode_q==1: r even -> r>>1; r odd -> (r>>1)+1665.
  - Otherwise the result is r.
  - Result is always in 0..3328.
  - Non-canonical inputs give an unspecified value but must not disturb sequencing.
- Back-to-back passes: start asserted in the cycle after done is accepted (state IDLE). No overlap between passes.
- wr_data holds its last value when wr_en=0.

Optional Feature:
- Macro RANGE_CHK_EN.
- When defined:
  - Adds output range_err (1 bit, reset 0).
  - range_err is cleared when start is accepted.
  - It is set sticky when a returning rd_a or rd_b is >=3329 on a valid read-data cycle.
  - It is held until the next accepted start or reset, and is valid by the done cycle.
- When undefined: the port is absent and no comparison logic is present. Sequencing and results are identical either way.

Test Plan:
- Reset then idle, with N=256, RD_LAT=1. start at cycle 0 with mode=0, every memory word A=3000, B=500 -> 256 writes, cycles 3..258, addr 0..255, wr_data=171; done only in cycle 259; busy cycles 1..259.
- mode=1 with A=3000, B=500 -> wr_data=1750. mode=1 with A=3328, B=3328 -> 3328. mode=1 with A=2, B=4 -> 3. mode=3 with A=3000, B=500 -> 171 (add only).
- RD_LAT=3 instance, A[k]=k, B[k]=k, mode=0 -> wr_addr=k, wr_data=2k; first write 4 cycles after first rd_en; done 1 cycle after write 255.
- start pulsed again in cycle 100 of a pass and mode toggled mid-pass -> ignored; exactly 256 writes with the original mode.
- rst_n low in cycle 50, start pulsed again at cycle 60 -> all outputs 0 in cycle 51; no done for the aborted pass; new pass complete and correct.
- RANGE_CHK_EN defined, B[17]=3329 -> range_err=1 by done; next pass with clean data -> range_err=0 after start.

Source files
------------

// File: rtl/poly_add_half_seq.sv
// rtl/poly_add_half_seq.sv - Kyber poly add / add-and-halve sequencer over dual-read coefficient memory
// Optional macro RANGE_CHK_EN adds the sticky range_err output for non-canonical operands.
module poly_add_half_seq #(
    parameter int N      = 256,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [11:0]       rd_a,
    input  logic [11:0]       rd_b,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       wr_data
`ifdef RANGE_CHK_EN
    ,
    output logic              range_err
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          drain_q, drain_d;
    logic [RD_LAT-1:0]   vld_q, vld_d;
    logic [ADDR_W-1:0]   padr_q [RD_LAT];
    logic [ADDR_W-1:0]   padr_d [RD_LAT];
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [11:0]         wr_data_q, wr_data_d;

    logic [12:0]         sum;
    logic [11:0]         red;
    logic [11:0]         half;
    logic [11:0]         res;

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == FIN);
    assign rd_en   = (state_q == RUN);
    assign rd_addr = addr_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

    // Halving mod q: odd r becomes (r+q)/2 = (r>>1) + (q+1)/2.
    always_comb begin
        sum  = {1'b0, rd_a} + {1'b0, rd_b};
        red  = (sum >= 13'd3329) ? 12'(sum - 13'd3329) : sum[11:0];
        half = {1'b0, red[11:1]} + (red[0] ? 12'd1665 : 12'd0);
        res  = (mode_q == 2'd1) ? half : red;
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    mode_d  = mode;
                    addr_d  = '0;
                end
            end
            RUN: begin
                addr_d = addr_q + ADDR_W'(1);
                if (addr_q == ADDR_W'(N - 1)) begin
                    state_d = DRAIN;
                    drain_d = 2'd0;
                end
            end
            DRAIN: begin
                drain_d = drain_q + 2'd1;
                // Last read returns after RD_LAT cycles, plus one for the result register.
                if (drain_q == 2'(RD_LAT)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        vld_d     = '0;
        vld_d[0]  = rd_en;
        padr_d[0] = rd_addr;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i]  = vld_q[i-1];
            padr_d[i] = padr_q[i-1];
        end
        wr_en_d   = vld_q[RD_LAT-1];
        wr_addr_d = vld_q[RD_LAT-1] ? padr_q[RD_LAT-1] : wr_addr_q;
        wr_data_d = vld_q[RD_LAT-1] ? res : wr_data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mode_q    <= 2'd0;
            addr_q    <= '0;
            drain_q   <= 2'd0;
            vld_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 12'd0;
            for (int i = 0; i < RD_LAT; i++) begin
                padr_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            addr_q    <= addr_d;
            drain_q   <= drain_d;
            vld_q     <= vld_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            for (int i = 0; i < RD_LAT; i++) begin
                padr_q[i] <= padr_d[i];
            end
        end
    end

`ifdef RANGE_CHK_EN
    logic range_err_q, range_err_d;

    always_comb begin
        range_err_d = range_err_q;
        if ((state_q == IDLE) && start) begin
            range_err_d = 1'b0;
        end
        if (vld_q[RD_LAT-1] && ((rd_a >= 12'd3329) || (rd_b >= 12'd3329))) begin
            range_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            range_err_q <= 1'b0;
        end else begin
            range_err_q <= range_err_d;
        end
    end

    assign range_err = range_err_q;
`endif

endmodule

// File: tb/tb_poly_add_half_seq.sv
// tb/tb_poly_add_half_seq.sv - self-checking bench for poly_add_half_seq (RD_LAT=1 and RD_LAT=3 instances)
module tb_poly_add_half_seq;

    localparam int N = 256;

    typedef struct {
        logic [1:0]  mode;
        logic [11:0] a;
        logic [11:0] b;
        logic [11:0] exp;
    } vec_t;

    typedef struct {
        logic [7:0]  addr;
        logic [11:0] data;
        int          cyc;
        bit          dc;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start1, start3;
    logic [1:0]  mode1, mode3;
    logic        busy1, done1, rd_en1, wr_en1;
    logic        busy3, done3, rd_en3, wr_en3;
    logic [7:0]  rd_addr1, wr_addr1, rd_addr3, wr_addr3;
    logic [11:0] rd_a1, rd_b1, wr_data1, rd_a3, rd_b3, wr_data3;
    logic [11:0] p1a, p1b, p2a, p2b;
`ifdef RANGE_CHK_EN
    logic        range_err1, range_err3;
`endif

    logic [11:0] mem_a [N];
    logic [11:0] mem_b [N];
    logic [11:0] exp_arr [N];
    bit          dc [N];

    wr_t  q[$];
    vec_t vt [11];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t0 = 0;
    bit sel = 1'b0;
    int rd_cnt, wr_cnt, done_cnt, done_cyc, busy_cnt, busy_first;

    poly_add_half_seq #(.N(N), .ADDR_W(8), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode1),
        .busy(busy1), .done(done1), .rd_en(rd_en1), .rd_addr(rd_addr1),
        .rd_a(rd_a1), .rd_b(rd_b1), .wr_en(wr_en1), .wr_addr(wr_addr1),
        .wr_data(wr_data1)
`ifdef RANGE_CHK_EN
        , .range_err(range_err1)
`endif
    );

    poly_add_half_seq #(.N(N), .ADDR_W(8), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .mode(mode3),
        .busy(busy3), .done(done3), .rd_en(rd_en3), .rd_addr(rd_addr3),
        .rd_a(rd_a3), .rd_b(rd_b3), .wr_en(wr_en3), .wr_addr(wr_addr3),
        .wr_data(wr_data3)
`ifdef RANGE_CHK_EN
        , .range_err(range_err3)
`endif
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rd_en1) begin
            rd_a1 <= mem_a[rd_addr1];
            rd_b1 <= mem_b[rd_addr1];
        end
        p1a   <= mem_a[rd_addr3];
        p1b   <= mem_b[rd_addr3];
        p2a   <= p1a;
        p2b   <= p1b;
        rd_a3 <= p2a;
        rd_b3 <= p2b;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        logic        we, de, be, re;
        logic [7:0]  wa, ra;
        logic [11:0] wd;
        int          rel;
        wr_t         e;
        we  = sel ? wr_en3   : wr_en1;
        de  = sel ? done3    : done1;
        be  = sel ? busy3    : busy1;
        re  = sel ? rd_en3   : rd_en1;
        wa  = sel ? wr_addr3 : wr_addr1;
        ra  = sel ? rd_addr3 : rd_addr1;
        wd  = sel ? wr_data3 : wr_data1;
        rel = cyc - t0;
        if (re) begin
            rd_cnt++;
            chk("rd_addr", {24'd0, ra}, 32'(rel - 1));
        end
        if (we) begin
            wr_cnt++;
            chk("wr_pending", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("wr_addr", {24'd0, wa}, {24'd0, e.addr});
                if (!e.dc) chk("wr_data", {20'd0, wd}, {20'd0, e.data});
                chk("wr_cycle", rel, e.cyc);
            end
        end
        if (de) begin
            done_cnt++;
            done_cyc = rel;
        end
        if (be) begin
            busy_cnt++;
            if (busy_first < 0) busy_first = rel;
        end
    end

    task automatic fill_const(input logic [11:0] a, input logic [11:0] b, input logic [11:0] e);
        for (int k = 0; k < N; k++) begin
            mem_a[k]   = a;
            mem_b[k]   = b;
            exp_arr[k] = e;
            dc[k]      = 1'b0;
        end
    endtask

    task automatic drive_start(input bit d, input logic s, input logic [1:0] m);
        if (d) begin
            start3 = s;
            mode3  = m;
        end else begin
            start1 = s;
            mode1  = m;
        end
    endtask

    task automatic clear_counts();
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0; done_cyc = -1; busy_cnt = 0; busy_first = -1;
    endtask

    task automatic load_sb(input int lat);
        wr_t e;
        for (int k = 0; k < N; k++) begin
            e.addr = 8'(k);
            e.data = exp_arr[k];
            e.cyc  = k + lat + 2;
            e.dc   = dc[k];
            q.push_back(e);
        end
    endtask

    // Start in cycle 0 of the pass; returns after the done cycle has been sampled.
    task automatic run_pass(input bit d, input logic [1:0] m, input int restart_at, input int toggle_at);
        int lat;
        lat = d ? 3 : 1;
        sel = d;
        load_sb(lat);
        clear_counts();
        @(posedge clk); #1;
        t0 = cyc;
        drive_start(d, 1'b1, m);
        while (cyc - t0 < N + lat + 2) begin
            @(posedge clk); #1;
            drive_start(d, (cyc - t0 == restart_at),
                        (toggle_at >= 0 && cyc - t0 >= toggle_at) ? ~m : m);
        end
        @(negedge clk); #1;
        drive_start(d, 1'b0, m);
        chk("wr_count", wr_cnt, N);
        chk("rd_count", rd_cnt, N);
        chk("done_count", done_cnt, 1);
        chk("done_cycle", done_cyc, N + lat + 2);
        chk("busy_count", busy_cnt, N + lat + 2);
        chk("busy_first", busy_first, 1);
        chk("sb_left", q.size(), 0);
        q.delete();
    endtask

    initial begin
        vt[0]  = '{2'd0, 12'd3000, 12'd500,  12'd171};
        vt[1]  = '{2'd1, 12'd3000, 12'd500,  12'd1750};
        vt[2]  = '{2'd1, 12'd3328, 12'd3328, 12'd3328};
        vt[3]  = '{2'd1, 12'd2,    12'd4,    12'd3};
        vt[4]  = '{2'd3, 12'd3000, 12'd500,  12'd171};
        vt[5]  = '{2'd0, 12'd0,    12'd0,    12'd0};
        vt[6]  = '{2'd0, 12'd3328, 12'd1,    12'd0};
        vt[7]  = '{2'd1, 12'd3328, 12'd1,    12'd0};
        vt[8]  = '{2'd1, 12'd0,    12'd1,    12'd1665};
        vt[9]  = '{2'd2, 12'd1664, 12'd1665, 12'd0};
        vt[10] = '{2'd0, 12'd1664, 12'd1664, 12'd3328};

        rst_n = 1'b0;
        start1 = 1'b0; mode1 = 2'd0;
        start3 = 1'b0; mode3 = 2'd0;
        clear_counts();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs_lat1", {busy1, done1, rd_en1, wr_en1, rd_addr1, wr_addr1, wr_data1}, 32'd0);
        chk("reset_outs_lat3", {busy3, done3, rd_en3, wr_en3, rd_addr3, wr_addr3, wr_data3}, 32'd0);
`ifdef RANGE_CHK_EN
        chk("reset_range_err", {31'd0, range_err1}, 32'd0);
`endif
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("idle_busy", {31'd0, busy1}, 32'd0);

        // Back-to-back passes: each starts the cycle after the previous done.
        for (int i = 0; i < 11; i++) begin
            fill_const(vt[i].a, vt[i].b, vt[i].exp);
            run_pass(1'b0, vt[i].mode, -1, -1);
        end

        for (int k = 0; k < N; k++) begin
            mem_a[k]   = 12'(k);
            mem_b[k]   = 12'(k);
            exp_arr[k] = 12'(2 * k);
            dc[k]      = 1'b0;
        end
        run_pass(1'b1, 2'd0, -1, -1);

        fill_const(12'd3000, 12'd500, 12'd1750);
        run_pass(1'b0, 2'd1, 100, 10);

        // Abort with reset in cycle 50, restart in cycle 60.
        fill_const(12'd3000, 12'd500, 12'd171);
        sel = 1'b0;
        load_sb(1);
        clear_counts();
        @(posedge clk); #1;
        t0 = cyc;
        start1 = 1'b1; mode1 = 2'd0;
        while (cyc - t0 < 50) begin
            @(posedge clk); #1;
            start1 = 1'b0;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("abort_outs", {busy1, done1, rd_en1, wr_en1, rd_addr1, wr_addr1, wr_data1}, 32'd0);
        chk("abort_wr_count", wr_cnt, 48);
        q.delete();
        while (cyc - t0 < 59) begin
            @(posedge clk); #1;
        end
        chk("abort_no_done", done_cnt, 0);
        chk("abort_idle", {31'd0, busy1}, 32'd0);
        run_pass(1'b0, 2'd0, -1, -1);

`ifdef RANGE_CHK_EN
        fill_const(12'd0, 12'd0, 12'd0);
        mem_b[17] = 12'd3329;
        dc[17]    = 1'b1;
        run_pass(1'b0, 2'd0, -1, -1);
        chk("range_err_set", {31'd0, range_err1}, 32'd1);
        fill_const(12'd0, 12'd0, 12'd0);
        run_pass(1'b0, 2'd0, -1, -1);
        chk("range_err_clear", {31'd0, range_err1}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
